// File: rtl/sad_accum_engine_if.sv
// Control, memory-write and result signals of sad_accum_engine.
// The master modport is the loader side; the slave modport is the engine.
interface sad_accum_engine_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned SUM_W  = WIDTH + ADDR_W
);
   logic              go;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W:0]   length;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              busy;
   logic              done;
   logic [SUM_W-1:0]  sum;
   logic              sat;

   modport master (
      output go, start_addr, length, wr_en, wr_addr, wr_data,
      input  busy, done, sum, sat
   );

   modport slave (
      input  go, start_addr, length, wr_en, wr_addr, wr_data,
      output busy, done, sum, sat
   );
endinterface

// File: rtl/sad_accum_engine.sv
// Sum of |mem[k] - mem[k+1]| over a wrapping window of an internal register file.
// Define SAD_SAT_EN to saturate the accumulator and report clipping on sat.
module sad_accum_engine #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = $clog2(DEPTH),
   parameter int unsigned SUM_W  = WIDTH + ADDR_W
) (
   input logic               Clk,
   input logic               Rst,
   sad_accum_engine_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam logic [ADDR_W:0] DepthL = (ADDR_W + 1)'(DEPTH);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [WIDTH-1:0]  prev_q, prev_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [SUM_W-1:0]  sum_q, sum_d;

   logic              mem_we;
   logic [ADDR_W:0]   len_eff;
   logic [WIDTH-1:0]  first_val;
   logic [WIDTH-1:0]  cur;
   logic [WIDTH-1:0]  diff;
   logic [SUM_W-1:0]  acc_next;

`ifdef SAD_SAT_EN
   logic              sat_q, sat_d;
   logic [SUM_W:0]    add_full;
   logic              clip;
`endif

   always_comb begin
      mem_we  = (state_q == StIdle) && bus.wr_en;
      len_eff = (bus.length > DepthL) ? DepthL : bus.length;
      // A write landing with an accepted go must be seen by the first read.
      first_val = (mem_we && (bus.wr_addr == bus.start_addr)) ? bus.wr_data
                                                               : mem_q[bus.start_addr];
      cur  = mem_q[ptr_q];
      diff = (prev_q > cur) ? (prev_q - cur) : (cur - prev_q);
`ifdef SAD_SAT_EN
      add_full = {1'b0, sum_q} + (SUM_W + 1)'(diff);
      clip     = add_full[SUM_W];
      acc_next = clip ? {SUM_W{1'b1}} : add_full[SUM_W-1:0];
`else
      acc_next = sum_q + SUM_W'(diff);
`endif
   end

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      sum_d   = sum_q;
`ifdef SAD_SAT_EN
      sat_d   = sat_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.go) begin
               len_d = len_eff;
               sum_d = '0;
`ifdef SAD_SAT_EN
               sat_d = 1'b0;
`endif
               if (len_eff >= (ADDR_W + 1)'(2)) begin
                  prev_d  = first_val;
                  ptr_d   = bus.start_addr + 1'b1;
                  cnt_d   = (ADDR_W + 1)'(1);
                  state_d = StRun;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StRun: begin
            sum_d  = acc_next;
            prev_d = cur;
            ptr_d  = ptr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
`ifdef SAD_SAT_EN
            if (clip) sat_d = 1'b1;
`endif
            if (cnt_q == len_q - 1'b1) state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= StIdle;
         prev_q  <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         sum_q   <= sum_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[bus.wr_addr] <= bus.wr_data;
      end
   end

`ifdef SAD_SAT_EN
   always_ff @(posedge Clk) begin
      if (Rst) sat_q <= 1'b0;
      else     sat_q <= sat_d;
   end
   assign bus.sat = sat_q;
`else
   assign bus.sat = 1'b0;
`endif

   assign bus.busy = (state_q != StIdle);
   assign bus.done = (state_q == StDone);
   assign bus.sum  = sum_q;

endmodule

// File: tb/tb_sad_accum_engine.sv
// Randomised scoreboard bench for sad_accum_engine: a wide-sum instance and a 9-bit-sum
// instance share the same stimulus; a monitor checks every done pulse against a window model.
module tb_sad_accum_engine;

   localparam int Depth = 32;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       go = 1'b0;
   logic [4:0] start_addr = '0;
   logic [5:0] length = '0;
   logic       wr_en = 1'b0;
   logic [4:0] wr_addr = '0;
   logic [7:0] wr_data = '0;

   sad_accum_engine_if #(.WIDTH(8), .ADDR_W(5), .SUM_W(13)) ifa ();
   sad_accum_engine_if #(.WIDTH(8), .ADDR_W(5), .SUM_W(9))  ifb ();

   assign ifa.go = go;  assign ifa.start_addr = start_addr;  assign ifa.length = length;
   assign ifa.wr_en = wr_en;  assign ifa.wr_addr = wr_addr;  assign ifa.wr_data = wr_data;
   assign ifb.go = go;  assign ifb.start_addr = start_addr;  assign ifb.length = length;
   assign ifb.wr_en = wr_en;  assign ifb.wr_addr = wr_addr;  assign ifb.wr_data = wr_data;

   sad_accum_engine #(.WIDTH(8), .DEPTH(32)) dut (.Clk(Clk), .Rst(Rst), .bus(ifa));
   sad_accum_engine #(.WIDTH(8), .DEPTH(32), .SUM_W(9)) dut9 (.Clk(Clk), .Rst(Rst), .bus(ifb));

   always #5 Clk = ~Clk;

   typedef struct {
      int sum;
      int sum9;
      int sat9;
      int done_cyc;
      int busy_len;
   } exp_t;

   exp_t q[$];
   int   mem_m [Depth];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   busy_cnt = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain sum over the wrapped window, then wrap or clip to the sum width.
   task automatic model(input int s, input int len, output exp_t e);
      int l;
      int t;
      int a;
      int b;
      l = (len > Depth) ? Depth : len;
      t = 0;
      for (int k = 0; k < l - 1; k++) begin
         a = mem_m[(s + k) % Depth];
         b = mem_m[(s + k + 1) % Depth];
         t += (a > b) ? a - b : b - a;
      end
      e.sum = t % 8192;
`ifdef SAD_SAT_EN
      e.sum9 = (t > 511) ? 511 : t;
      e.sat9 = (t > 511) ? 1 : 0;
`else
      e.sum9 = t % 512;
      e.sat9 = 0;
`endif
      e.busy_len = (l < 2) ? 1 : l;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic write_mem(input int a, input int d);
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = 8'(d);
      tick();
      wr_en = 1'b0;
      mem_m[a] = d;
   endtask

   task automatic start_run(input int s, input int len, input bit we, input int wa, input int wd);
      exp_t e;
      go = 1'b1; start_addr = 5'(s); length = 6'(len);
      wr_en = we; wr_addr = 5'(wa); wr_data = 8'(wd);
      if (we) mem_m[wa] = wd;
      model(s, len, e);
      tick();
      go = 1'b0; wr_en = 1'b0;
      e.done_cyc = cyc + e.busy_len - 1;
      q.push_back(e);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (!ifa.busy) return;
         tick();
      end
      check("idle_timeout", 1, 0);
   endtask

   always @(negedge Clk) begin
      exp_t e;
      if (Rst) busy_cnt = 0;
      else if (ifa.busy === 1'b1) busy_cnt++;
      if (ifa.done === 1'b1 || ifb.done === 1'b1) begin
         check("done_align", int'(ifb.done), int'(ifa.done));
         if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = q.pop_front();
            check("sum", int'(ifa.sum), e.sum);
            check("sum9", int'(ifb.sum), e.sum9);
            check("sat9", int'(ifb.sat), e.sat9);
            check("sat_wide", int'(ifa.sat), 0);
            check("done_cycle", cyc, e.done_cyc);
            check("busy_cycles", busy_cnt, e.busy_len);
         end
      end
      if (ifa.busy === 1'b0) busy_cnt = 0;
   end

   initial begin
      for (int i = 0; i < Depth; i++) mem_m[i] = 0;
      Rst = 1'b1;
      tick(); tick();
      Rst = 1'b0;
      tick();
      check("rst_busy", int'(ifa.busy), 0);
      check("rst_done", int'(ifa.done), 0);
      check("rst_sum", int'(ifa.sum), 0);
      check("rst_sat9", int'(ifb.sat), 0);

      for (int k = 0; k < Depth; k++) write_mem(k, k);
      start_run(0, 32, 0, 0, 0);
      wait_idle();

      write_mem(30, 200); write_mem(31, 10); write_mem(0, 250);
      start_run(30, 3, 0, 0, 0);
      wait_idle();

      start_run(4, 1, 0, 0, 0);   wait_idle();
      start_run(4, 0, 0, 0, 0);   wait_idle();
      start_run(7, 40, 0, 0, 0);  wait_idle();
      start_run(1, 2, 1, 1, 123); wait_idle();

      // Write and go during a run must both be dropped.
      start_run(0, 32, 0, 0, 0);
      tick(); tick(); tick();
      go = 1'b1; start_addr = 5'd9; length = 6'd5;
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'd99;
      tick();
      go = 1'b0; wr_en = 1'b0;
      wait_idle();
      start_run(3, 5, 0, 0, 0);
      wait_idle();

      write_mem(0, 0); write_mem(1, 255); write_mem(2, 0); write_mem(3, 255);
      start_run(0, 4, 0, 0, 0);
      wait_idle();

      for (int it = 0; it < 25; it++) begin
         int nw;
         nw = int'($urandom_range(0, 3));
         for (int w = 0; w < nw; w++)
            write_mem(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
         start_run(int'($urandom_range(0, 31)), int'($urandom_range(0, 40)),
                   ($urandom_range(0, 3) == 0), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 255)));
         wait_idle();
      end

      // Reset mid-run: no done, everything cleared.
      start_run(0, 32, 0, 0, 0);
      tick(); tick(); tick(); tick();
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      q.delete();
      for (int i = 0; i < Depth; i++) mem_m[i] = 0;
      check("abort_busy", int'(ifa.busy), 0);
      check("abort_sum", int'(ifa.sum), 0);
      check("abort_done", int'(ifa.done), 0);
      tick();
      start_run(0, 32, 0, 0, 0);
      wait_idle();
      tick();

      check("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
